ntt_ct_butterfly: RTL
=====================

// Module: ntt_ct_butterfly
// PURPOSE
//  Cooley-Tukey NTT butterfly around the external Barrett reduction stage.
//  Computes t = (b*w) mod q and outputs x = (a+t) mod q and y = (a-t) mod q.
//  Stage 1 forms the 64-bit product b*w and drives it into the reducer's din port.
//  Operand a waits in an in-order FIFO. It is popped when the reducer's dout_valid
//  returns, and both modular add/sub results are registered together.
// PARAMETERS
//  PARAM_K    32          operand width in bits
//  PARAM_MOD  4294966657  modulus q; all operands are < q
//  MUL_LAT    4           product pipeline depth in cycles (>=1)
//  FIFO_AW    5           a-FIFO address width; depth = 2**FIFO_AW = 32
// PORTS
//  clk            in   1   clock
//  rst_b          in   1   synchronous reset, active-low
//  din_valid      in   1   input triple valid
//  din_ready      out  1   FIFO not full; a triple is accepted iff din_valid&din_ready
//  din_a          in   32  butterfly upper operand a
//  din_b          in   32  butterfly lower operand b
//  din_w          in   32  twiddle factor w
//  red_din        out  64  product b*w, to reducer din
//  red_din_valid  out  1   to reducer din_valid
//  red_dout       in   32  reduced product t, from reducer dout
//  red_dout_valid in   1   from reducer dout_valid
//  dout_x         out  32  (a+t) mod q
//  dout_y         out  32  (a-t) mod q
//  dout_valid     out  1   dout_x/dout_y valid, single-cycle pulse per result
//  err_clr        in   1   clears sticky error flags
//  ovf_err        out  1   sticky: din_valid seen while din_ready=0; that input is dropped
//  unf_err        out  1   sticky: red_dout_valid seen while FIFO empty
// BEHAVIOUR
//  Reset (rst_b=0 at posedge): all outputs are 0 except din_ready.
//   - din_ready=1 in the cycle after reset.
//   - Product pipeline valids are cleared. FIFO rd/wr pointers and count are 0.
//   - rst_b is shared with the reducer. Reset mid-operation discards all in-flight work.
//  Accept: on accept, din_a is pushed into the FIFO, and b*w enters a MUL_LAT-stage pipe.
//   - red_din_valid rises exactly MUL_LAT cycles after the accept edge.
//   - red_din = din_b*din_w at full 64 bits; no truncation, since (q-1)^2 < 2^64.
//   - Non-accepted cycles propagate valid=0. red_din holds its last value.
//  din_ready = (count != 2**FIFO_AW). It does not depend on a same-cycle pop.
//  Pop: on red_dout_valid with count!=0, the FIFO head a is combined with t=red_dout.
//   - The result is registered, so dout_valid follows red_dout_valid by 1 cycle.
//   - End-to-end latency = MUL_LAT + 13 (reducer) + 1.
//  Arithmetic (inputs a,t < q):
//   - s = a + t, computed at 33 bits. dout_x = (s >= q) ? s - q : s.
//   - dout_y = (a >= t) ? a - t : a - t + q, computed at 33 bits with the result truncated to 32.
//  Push and pop in the same cycle: count is unchanged and both are performed.
//   - When the FIFO is full, the push is refused because din_ready=0. The pop still occurs.
//  Pop while the FIFO is empty: no dout_valid is issued, outputs hold, and unf_err is set.
//   - A same-cycle push is not bypassed to the pop.
//  Pointers wrap modulo 2**FIFO_AW. count is FIFO_AW+1 bits wide.
//  Errors: set has priority over err_clr in the same cycle. Errors clear only via err_clr or reset.
//  dout_x, dout_y and red_din hold their values between valids. There is no downstream backpressure.
//  Ordering: the reducer is in-order and fixed-latency, so the FIFO head always matches red_dout.
// TESTING
//  1 Single op: a=5,b=3,w=7. Expect red_din=21 with red_din_valid at cycle +4.
//    With the reducer attached, dout_x=26 and dout_y=4294966641 at cycle +18.
//  2 Wrap: a=q-1 with b*w≡2. Expect dout_x=1, dout_y=q-3. Then a=1 with t=q-1: expect x=0, y=2.
//  3 Zero/identity: a=0,b=0,w=0 -> x=0,y=0. Then a=q-1,b=q-1,w=1 -> x=q-2, y=0.
//  4 Stream: 64 back-to-back random triples through the real reducer.
//    Outputs must match a golden model in order. din_ready stays 1 and both errors stay 0.
//  5 Overflow: a stub reducer never returns a result. After 32 accepts, din_ready=0.
//    A 33rd din_valid sets ovf_err=1. One red_dout_valid then pops a, and din_ready=1 next cycle.
//  6 Underflow/reset: red_dout_valid with an empty FIFO sets unf_err=1 with no dout_valid.
//    err_clr clears it. rst_b=0 mid-stream: next cycle, all valids=0, count=0, din_ready=1.

Source files
------------

// File: rtl/ntt_ct_butterfly.sv
// Cooley-Tukey NTT butterfly wrapped around an external fixed-latency Barrett reducer.
// Forms b*w for the reducer, queues a in order, and emits (a+t) mod q / (a-t) mod q.
module ntt_ct_butterfly #(
  parameter int unsigned     PARAM_K   = 32,
  parameter longint unsigned PARAM_MOD = 64'd4294966657,
  parameter int unsigned     MUL_LAT   = 4,
  parameter int unsigned     FIFO_AW   = 5
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [PARAM_K-1:0]     din_a,
  input  logic [PARAM_K-1:0]     din_b,
  input  logic [PARAM_K-1:0]     din_w,
  output logic [2*PARAM_K-1:0]   red_din,
  output logic                   red_din_valid,
  input  logic [PARAM_K-1:0]     red_dout,
  input  logic                   red_dout_valid,
  output logic [PARAM_K-1:0]     dout_x,
  output logic [PARAM_K-1:0]     dout_y,
  output logic                   dout_valid,
  input  logic                   err_clr,
  output logic                   ovf_err,
  output logic                   unf_err
);

  localparam int unsigned      DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [PARAM_K:0] Q_EXT    = (PARAM_K + 1)'(PARAM_MOD);

  function automatic logic [PARAM_K-1:0] mod_add(input logic [PARAM_K-1:0] a,
                                                 input logic [PARAM_K-1:0] t);
    logic [PARAM_K:0] s;
    s = {1'b0, a} + {1'b0, t};
    if (s >= Q_EXT) s = s - Q_EXT;
    return s[PARAM_K-1:0];
  endfunction

  // Borrow case wraps back into [0,q); the 33-bit result always fits in 32 bits.
  function automatic logic [PARAM_K-1:0] mod_sub(input logic [PARAM_K-1:0] a,
                                                 input logic [PARAM_K-1:0] t);
    logic [PARAM_K:0] d;
    d = {1'b0, a} - {1'b0, t};
    if (a < t) d = d + Q_EXT;
    return d[PARAM_K-1:0];
  endfunction

  logic [PARAM_K-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     cnt_q, cnt_d;
  logic [2*PARAM_K-1:0] prod_q [MUL_LAT];
  logic [MUL_LAT-1:0]   vld_q;
  logic [PARAM_K-1:0]   x_q, y_q;
  logic                 dval_q, ovf_q, unf_q;
  logic                 push, pop, fifo_empty;
  logic [2*PARAM_K-1:0] prod_p0;

  assign din_ready  = (cnt_q != FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign push       = din_valid & din_ready;
  assign pop        = red_dout_valid & ~fifo_empty;
  assign prod_p0    = (2 * PARAM_K)'(din_b) * (2 * PARAM_K)'(din_w);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Product pipeline: each stage loads only behind a valid, so red_din holds between results.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      vld_q <= '0;
      for (int i = 0; i < int'(MUL_LAT); i++) prod_q[i] <= '0;
    end else begin
      vld_q[0] <= push;
      if (push) prod_q[0] <= prod_p0;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) prod_q[i] <= prod_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din_a;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Result stage: FIFO head a meets t from the reducer; a new error event beats err_clr.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      x_q    <= '0;
      y_q    <= '0;
      dval_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      dval_q <= pop;
      if (pop) begin
        x_q <= mod_add(mem_q[rd_ptr_q], red_dout);
        y_q <= mod_sub(mem_q[rd_ptr_q], red_dout);
      end
      ovf_q <= (din_valid & ~din_ready) | (ovf_q & ~err_clr);
      unf_q <= (red_dout_valid & fifo_empty) | (unf_q & ~err_clr);
    end
  end

  assign red_din       = prod_q[MUL_LAT-1];
  assign red_din_valid = vld_q[MUL_LAT-1];
  assign dout_x        = x_q;
  assign dout_y        = y_q;
  assign dout_valid    = dval_q;
  assign ovf_err       = ovf_q;
  assign unf_err       = unf_q;

endmodule
